// File: rtl/sub_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial_ctrl
// Brief    : Wide A - B - Cin computed one nibble per cycle on a single shared
//            4-bit subtractor slice, with a registered borrow chain and a
//            Start/Busy/Done handshake. Optional Zero/Ovf flags: SUB_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================

module sub4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);
   logic [4:0] r;

   // A 5-bit difference leaves the borrow in the top bit when it goes negative
   assign r    = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
   assign d    = r[3:0];
   assign bout = r[4];
endmodule

module sub_serial_ctrl #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4 * NIBBLES
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Cin,
   output logic         Busy,
   output logic         Done,
   output logic [W-1:0] S,
   output logic         Cout
`ifdef SUB_FLAGS_EN
   ,
   output logic         Zero,
   output logic         Ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           accept;
   logic [2:0]     k;
   logic           last;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   s_q;
   logic [W-1:0]   s_nxt;
   logic           borrow;
   logic           cout_q;
   logic [3:0]     a_nib;
   logic [3:0]     b_nib;
   logic [3:0]     d_nib;
   logic           bout;

   assign last  = (k == 3'(NIBBLES - 1));
   assign a_nib = a_q[{k, 2'b00} +: 4];
   assign b_nib = b_q[{k, 2'b00} +: 4];

   sub4_slice u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .bin  (borrow),
      .d    (d_nib),
      .bout (bout)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      Busy = (state == RUN);
      Done = (state == DONE);
   end

   // Result with the current nibble merged in; also feeds the flag logic
   always_comb begin
      s_nxt                     = s_q;
      s_nxt[{k, 2'b00} +: 4]    = d_nib;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         borrow <= 1'b0;
         cout_q <= 1'b0;
         k      <= 3'd0;
      end else if (accept) begin
         a_q    <= A;
         b_q    <= B;
         s_q    <= '0;
         borrow <= Cin;
         cout_q <= 1'b0;
         k      <= 3'd0;
      end else if (state == RUN) begin
         s_q    <= s_nxt;
         borrow <= bout;
         if (last) begin
            cout_q <= bout;
            k      <= 3'd0;
         end else begin
            k      <= k + 3'd1;
         end
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;

`ifdef SUB_FLAGS_EN
   logic zero_q;
   logic ovf_q;

   // Flags are judged on the completed result, i.e. on the edge entering DONE
   always_ff @(posedge Clk) begin
      if (Rst || accept) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state == RUN && last) begin
         zero_q <= (s_nxt == '0);
         ovf_q  <= (a_q[W-1] != b_q[W-1]) && (s_nxt[W-1] != a_q[W-1]);
      end
   end

   assign Zero = zero_q;
   assign Ovf  = ovf_q;
`else
   // Flag outputs and their state are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_serial_ctrl
// Brief    : Scoreboard bench for sub_serial_ctrl (NIBBLES=4, W=16).
// Revision : 1.0 - initial release
// ============================================================================

module tb_sub_serial_ctrl;

   localparam int W = 16;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         Start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Cin = 1'b0;
   logic         Busy;
   logic         Done;
   logic [W-1:0] S;
   logic         Cout;
`ifdef SUB_FLAGS_EN
   logic         Zero;
   logic         Ovf;
`endif

   sub_serial_ctrl #(.NIBBLES(4)) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .Busy  (Busy),
      .Done  (Done),
      .S     (S),
      .Cout  (Cout)
`ifdef SUB_FLAGS_EN
      ,
      .Zero  (Zero),
      .Ovf   (Ovf)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         z;
      logic         o;
   } exp_t;

   exp_t exp_q[$];
   int   total    = 0;
   int   bad      = 0;
   int   done_cnt = 0;

   // Scoreboard: every Done pops one expected result
   always @(negedge Clk) begin
      exp_t e;
      if (!Rst && Done) begin
         done_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: S=%h Cout=%b with no pending request", S, Cout);
         end else begin
            e = exp_q.pop_front();
            if (S !== e.s || Cout !== e.c) begin
               bad++;
               $display("FAIL result: got S=%h Cout=%b expected S=%h Cout=%b", S, Cout, e.s, e.c);
            end
`ifdef SUB_FLAGS_EN
            total++;
            if (Zero !== e.z || Ovf !== e.o) begin
               bad++;
               $display("FAIL flags: got Zero=%b Ovf=%b expected Zero=%b Ovf=%b", Zero, Ovf, e.z, e.o);
            end
`endif
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      logic [W:0] r;
      exp_t       e;
      r   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      e.s = r[W-1:0];
      e.c = r[W];
      e.z = (r[W-1:0] == '0);
      e.o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      exp_q.push_back(e);
   endtask

   // Returns one time unit after the accepting edge (start of cycle 1)
   task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input bit push);
      @(posedge Clk); #1;
      A = a; B = b; Cin = cin; Start = 1'b1;
      if (push) push_exp(a, b, cin);
      @(posedge Clk); #1;
      Start = 1'b0;
      A = $urandom(); B = $urandom(); Cin = 1'($urandom());
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 40) begin
         @(negedge Clk);
         n++;
      end
      @(negedge Clk);
      if (done_cnt < target) begin
         total++;
         bad++;
         $display("FAIL done_timeout: done_cnt=%0d expected %0d", done_cnt, target);
      end
   endtask

   task automatic test_reset;
      Rst = 1'b1;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      @(negedge Clk);
      total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", Done); end
      total++; if (S !== '0)      begin bad++; $display("FAIL reset_s: got %h expected 0000", S); end
      total++; if (Cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b expected 0", Cout); end
   endtask

   task automatic test_basic;
      int base = done_cnt;
      pulse_start(16'h1234, 16'h0234, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge Clk);
         total++;
         if (Busy !== 1'b1 || Done !== 1'b0) begin
            bad++;
            $display("FAIL busy_cycle%0d: got Busy=%b Done=%b expected Busy=1 Done=0", i, Busy, Done);
         end
      end
      @(negedge Clk);
      total++;
      if (Busy !== 1'b0 || Done !== 1'b1) begin
         bad++;
         $display("FAIL done_latency: got Busy=%b Done=%b expected Busy=0 Done=1", Busy, Done);
      end
      wait_done(base + 1);
   endtask

   task automatic test_wrap;
      int base = done_cnt;
      pulse_start(16'h0000, 16'h0001, 1'b0, 1'b1);
      wait_done(base + 1);
      pulse_start(16'h0010, 16'h0000, 1'b1, 1'b1);
      wait_done(base + 2);
   endtask

   task automatic test_start_in_run;
      int base = done_cnt;
      pulse_start(16'h5555, 16'h1111, 1'b0, 1'b1);
      @(posedge Clk); #1;
      A = 16'hFFFF; B = 16'h0000; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      wait_done(base + 1);
      repeat (10) @(negedge Clk);
      total++;
      if (done_cnt !== base + 1) begin
         bad++;
         $display("FAIL ignored_start_dones: got %0d expected %0d", done_cnt - base, 1);
      end
   endtask

   task automatic test_reset_abort;
      int base = done_cnt;
      pulse_start(16'h1234, 16'h0001, 1'b0, 1'b0);
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", Busy); end
      total++; if (S !== '0)      begin bad++; $display("FAIL abort_s: got %h expected 0000", S); end
      total++; if (Cout !== 1'b0) begin bad++; $display("FAIL abort_cout: got %b expected 0", Cout); end
      repeat (8) @(negedge Clk);
      total++;
      if (done_cnt !== base) begin
         bad++;
         $display("FAIL abort_no_done: got %0d dones expected 0", done_cnt - base);
      end
      pulse_start(16'h0009, 16'h0003, 1'b0, 1'b1);
      wait_done(base + 1);
   endtask

   task automatic test_back_to_back;
      int nd = 0;
      int cyc = 0;
      int last_cyc = 0;
      @(posedge Clk); #1;
      A = 16'h0005; B = 16'h0007; Cin = 1'b0; Start = 1'b1;
      repeat (3) push_exp(16'h0005, 16'h0007, 1'b0);
      while (nd < 3 && cyc < 40) begin
         @(negedge Clk);
         cyc++;
         if (Done) begin
            if (nd > 0) begin
               total++;
               if (cyc - last_cyc != 5) begin
                  bad++;
                  $display("FAIL b2b_spacing: got %0d cycles expected 5", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            nd++;
            if (nd == 3) Start = 1'b0;
         end
      end
      Start = 1'b0;
      if (nd < 3) begin
         total++;
         bad++;
         $display("FAIL b2b_timeout: got %0d dones expected 3", nd);
      end
      repeat (3) @(negedge Clk);
   endtask

`ifdef SUB_FLAGS_EN
   task automatic test_flags;
      int base = done_cnt;
      pulse_start(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done(base + 1);
      pulse_start(16'h3C3C, 16'h3C3C, 1'b0, 1'b1);
      wait_done(base + 2);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_start_in_run();
      test_reset_abort();
      test_back_to_back();
`ifdef SUB_FLAGS_EN
      test_flags();
`endif
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
